serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial add controller that time-shares a single 1-bit full adder (two half adders plus an OR on the carries) across WIDTH-bit operands. It captures both operands on a start request and walks the bits LSB-first, one bit per clock. It then presents the WIDTH-bit sum and final carry with a one-cycle done pulse. It sits in the ALU as the sequenced alternative to a parallel ripple adder, trading latency for area.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when the controller is not busy
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
sub  input  1  subtract select; captured with the operands; ignored unless SERIAL_SUB_EN is defined
sum  output  WIDTH  registered result; holds the last completed result
carry_out  output  1  registered final carry (the carry out of the MSB)
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous, active-low, and has priority over everything. It forces:
  - state=IDLE
  - sum=0, carry_out=0, busy=0, done=0
  - all internal shift registers, the carry flop and the bit counter cleared
- FSM has three states: IDLE, RUN, DONE.
- IDLE: if start=1 at a rising edge:
  - load shift_a<=a and shift_b<=b
  - set carry<=0 (or the subtract carry-in, see Optional Feature)
  - set cnt<=0 and move to RUN
  - otherwise stay in IDLE
- RUN, on each edge:
  - compute the full add of shift_a[0], shift_b[0] and carry using two half adders
  - shift the result bit into the MSB of shift_r (right shift)
  - shift shift_a and shift_b right by one
  - carry<=c1|c2
  - cnt<=cnt+1
- RUN exit: on the edge where cnt==WIDTH-1 (the last bit):
  - sum<=final shift_r and carry_out<=final carry, both written in the same edge
  - move to DONE
- DONE: done=1 for exactly one cycle.
  - If start=1 in DONE, it is accepted exactly as in IDLE and the FSM goes straight to RUN.
  - Otherwise the FSM returns to IDLE.
- busy=1 iff state==RUN. start while busy is ignored; it is neither queued nor does it affect the operation in flight.
- Latency: if start is sampled at edge E0, then done=1 and sum/carry_out are valid in the cycle after edge E(WIDTH). That is WIDTH edges after E0, so the throughput is 1 result per WIDTH+1 cycles.
- sum and carry_out change only at the completion edge (or reset). During RUN they hold the previous result.
- Counter width is $clog2(WIDTH)+1, so there is no wrap at WIDTH=32. WIDTH=1 completes in a single RUN cycle.
- Arithmetic is modulo 2^WIDTH. carry_out is the true carry out of bit WIDTH-1.
- Operand inputs a, b and sub may change freely after the accepting edge.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced and the outputs return to 0.

Optional Feature:
Macro: SERIAL_SUB_EN
- Defined:
  - sub=1 at the accepting edge loads shift_b<=~b and carry<=1, so sum=a-b (two's complement).
  - carry_out=1 means no borrow (a>=b unsigned); carry_out=0 means borrow.
  - sub=0 performs a normal add.
- Not defined:
  - the sub port still exists but is ignored, and no inversion logic is generated
  - the block always adds with carry-in 0

Test Plan:
1. Basic add: WIDTH=8, reset, then start with a=0x0F, b=0x01 -> busy for 8 cycles, done high for 1 cycle at edge E0+8, sum=0x10, carry_out=0. busy and done are 0 after reset.
2. Overflow: a=0xFF, b=0x01 -> sum=0x00, carry_out=1. Then a=0xA5, b=0x5A back-to-back, with start held high through DONE -> second result sum=0xFF, carry_out=0, with no IDLE cycle between the two operations.
3. Start while busy: start a=0x03, b=0x04, then pulse start with a=0xFF, b=0xFF at cycle 3 of RUN -> single done, sum=0x07. The second request is dropped, and sum keeps its prior value until the completion edge.
4. Reset mid-operation: start a=0x80, b=0x80, drop rst_n asynchronously (between edges) in RUN cycle 4 -> sum=0, carry_out=0, busy=0 immediately, no done pulse. A subsequent start of 0x01+0x01 gives sum=0x02.
5. WIDTH=1 instance: a=1, b=1 -> done at E0+1, sum=0, carry_out=1.
6. With SERIAL_SUB_EN defined:
   - a=0x07, b=0x05, sub=1 -> sum=0x02, carry_out=1
   - a=0x05, b=0x07, sub=1 -> sum=0xFE, carry_out=0
   - without the macro, the same stimulus gives sum=0x0C, carry_out=0 for the first case.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: request/result bundle for the bit-serial adder controller
// signals: start, a, b, sub (requester -> controller); sum, carry_out, busy, done (controller -> requester)
// modports: master (requester side), slave (controller side)
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;
  logic             done;
  modport master (output start, a, b, sub, input sum, carry_out, busy, done);
  modport slave (input start, a, b, sub, output sum, carry_out, busy, done);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sharing one full adder, LSB first, one bit per clock
// ports: clk (rising edge), rst_n (async active-low), io (slave modport: start/a/b/sub in, sum/carry_out/busy/done out)
// macro SERIAL_SUB_EN: when defined, sub=1 at the accepting edge computes a-b (carry_out=1 means no borrow)
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_adder_ctrl_if.slave io
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] shift_a, shift_b, shift_r, r_next, sum;
  logic [CW-1:0]    cnt;
  logic             carry, carry_out, s1, c1, s2, c2, load, last, busy, done;
  // two half adders plus an OR on their carries form the shared full adder
  always_comb begin
    s1 = shift_a[0] ^ shift_b[0];
    c1 = shift_a[0] & shift_b[0];
    s2 = s1 ^ carry;
    c2 = s1 & carry;
    r_next = shift_r >> 1;
    r_next[WIDTH-1] = s2;
    load = io.start && state != RUN;
    last = state == RUN && cnt == CW'(WIDTH - 1);
    state_n = load ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_a <= '0;
      shift_b <= '0;
      shift_r <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      carry_out <= 1'b0;
    end else if (load) begin
      shift_a <= io.a;
`ifdef SERIAL_SUB_EN
      shift_b <= io.sub ? ~io.b : io.b;
      carry <= io.sub;
`else
      shift_b <= io.b;
      carry <= 1'b0;
`endif
      cnt <= '0;
    end else if (state == RUN) begin
      shift_a <= shift_a >> 1;
      shift_b <= shift_b >> 1;
      shift_r <= r_next;
      carry <= c1 | c2;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum <= r_next;
        carry_out <= c1 | c2;
      end
    end
  end
`ifndef SERIAL_SUB_EN
  logic unused_sub;
  assign unused_sub = io.sub;
`endif
  assign io.sum = sum;
  assign io.carry_out = carry_out;
  assign io.busy = busy;
  assign io.done = done;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized and directed checks of serial_adder_ctrl (WIDTH=8 and WIDTH=1) against an arithmetic model
module tb_serial_adder_ctrl;
`ifdef SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] last_sum;
  logic last_co;
  always #5 clk = ~clk;
  serial_adder_ctrl_if #(.WIDTH(8)) i8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) i1 ();
  serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .io(i8));
  serial_adder_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .io(i1));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model(input int w, input logic [31:0] x, input logic [31:0] y, input logic s,
                       output logic [31:0] r, output logic co);
    logic [63:0] m, t;
    m = (64'd1 << w) - 64'd1;
    if (SUB_EN && s) begin
      r = (x - y) & m[31:0];
      co = x >= y;
    end else begin
      t = 64'(x) + 64'(y);
      r = t[31:0] & m[31:0];
      co = t[w];
    end
  endtask
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s, input int pulse_at);
    logic [31:0] er;
    logic eco;
    int n;
    model(8, 32'(x), 32'(y), s, er, eco);
    i8.start = 1'b1;
    i8.a = x;
    i8.b = y;
    i8.sub = s;
    @(posedge clk); #1;
    i8.start = 1'b0;
    i8.a = 8'($urandom);
    i8.b = 8'($urandom);
    i8.sub = 1'($urandom);
    check("busy", 64'(i8.busy), 64'(1));
    n = 0;
    while (!i8.done && n < 40) begin
      if (n == 4) check("hold", 64'({i8.carry_out, i8.sum}), 64'({last_co, last_sum}));
      if (n == pulse_at) begin
        i8.start = 1'b1;
        i8.a = '1;
        i8.b = '1;
      end else i8.start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    i8.start = 1'b0;
    check("latency", 64'(n), 64'(8));
    check("sum", 64'(i8.sum), 64'(er[7:0]));
    check("carry_out", 64'(i8.carry_out), 64'(eco));
    last_sum = er[7:0];
    last_co = eco;
  endtask
  task automatic gap();
    i8.start = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", 64'(i8.done), 64'(0));
    check("idle_busy", 64'(i8.busy), 64'(0));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] er;
    logic eco;
    logic [7:0] x, y;
    logic s;
    int n, nd;
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.sub = 1'b0;
    i1.start = 1'b0; i1.a = '0; i1.b = '0; i1.sub = 1'b0;
    last_sum = '0;
    last_co = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum", 64'(i8.sum), 64'(0));
    check("rst_co", 64'(i8.carry_out), 64'(0));
    check("rst_busy", 64'(i8.busy), 64'(0));
    check("rst_done", 64'(i8.done), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    op8(8'h0F, 8'h01, 1'b0, -1);
    check("t1_sum", 64'(i8.sum), 64'h10);
    check("t1_co", 64'(i8.carry_out), 64'(0));
    gap();
    op8(8'hFF, 8'h01, 1'b0, -1);
    check("t2_sum", 64'(i8.sum), 64'h00);
    check("t2_co", 64'(i8.carry_out), 64'(1));
    op8(8'hA5, 8'h5A, 1'b0, -1);
    check("t2b_sum", 64'(i8.sum), 64'hFF);
    check("t2b_co", 64'(i8.carry_out), 64'(0));
    gap();
    op8(8'h03, 8'h04, 1'b0, 2);
    check("t3_sum", 64'(i8.sum), 64'h07);
    gap();
    i8.a = 8'h80; i8.b = 8'h80; i8.sub = 1'b0; i8.start = 1'b1;
    @(posedge clk); #1;
    i8.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t4_sum", 64'(i8.sum), 64'(0));
    check("t4_co", 64'(i8.carry_out), 64'(0));
    check("t4_busy", 64'(i8.busy), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    last_sum = '0;
    last_co = 1'b0;
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (i8.done) nd++;
    end
    check("t4_no_done", 64'(nd), 64'(0));
    op8(8'h01, 8'h01, 1'b0, -1);
    check("t4_sum2", 64'(i8.sum), 64'h02);
    gap();
    op8(8'h07, 8'h05, 1'b1, -1);
`ifdef SERIAL_SUB_EN
    check("t6a_sum", 64'(i8.sum), 64'h02);
    check("t6a_co", 64'(i8.carry_out), 64'(1));
`else
    check("t6a_sum", 64'(i8.sum), 64'h0C);
    check("t6a_co", 64'(i8.carry_out), 64'(0));
`endif
    gap();
    op8(8'h05, 8'h07, 1'b1, -1);
`ifdef SERIAL_SUB_EN
    check("t6b_sum", 64'(i8.sum), 64'hFE);
    check("t6b_co", 64'(i8.carry_out), 64'(0));
`else
    check("t6b_sum", 64'(i8.sum), 64'h0C);
    check("t6b_co", 64'(i8.carry_out), 64'(0));
`endif
    gap();
    for (int i = 0; i < 8; i++) begin
      model(1, 32'(i & 1), 32'((i >> 1) & 1), 1'(i >> 2), er, eco);
      i1.a = 1'(i);
      i1.b = 1'(i >> 1);
      i1.sub = 1'(i >> 2);
      i1.start = 1'b1;
      @(posedge clk); #1;
      i1.start = 1'b0;
      n = 0;
      while (!i1.done && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      check("w1_latency", 64'(n), 64'(1));
      check("w1_sum", 64'(i1.sum), 64'(er[0]));
      check("w1_co", 64'(i1.carry_out), 64'(eco));
      @(posedge clk); #1;
      check("w1_done_pulse", 64'(i1.done), 64'(0));
    end
    repeat (60) begin
      x = 8'($urandom);
      y = 8'($urandom);
      s = 1'($urandom);
      op8(x, y, s, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1);
      if ($urandom_range(0, 2) != 0) gap();
    end
    gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
